fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RV32 core. Replaces the single-request, PC-driven instruction-memory hookup with a pipelined fetcher that keeps up to `MAX_OUTSTANDING` reads in flight, buffers returned instructions in a `DEPTH`-entry prefetch queue, and hands them to decode with a valid/ready handshake. A redirect port (branch/jump target) flushes the queue and discards stale in-flight responses. Sits between `inst_mem_req`/`inst_mem_rsp` and the decode stage.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/memory_io.sv | 18 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/memory_io.sv
// Memory-port request/response types shared by the core's memory clients.
package memory_io_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic        valid;
  } memory_io_req;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        valid;
  } memory_io_rsp;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr}; head is read straight from storage so a
// pushed entry is visible the cycle after its push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetcher: credit-limited read issue, in-order response
// capture into a prefetch queue, redirect flush with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
  import memory_io_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  reset_pc,
  output memory_io_req inst_mem_req,
  input  memory_io_rsp inst_mem_rsp,
  output logic         inst_mem_req_ack,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding, discard;
  logic [31:0]   in_use;
  logic          rsp_v, issue, q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head, q_in;

  assign rsp_v            = inst_mem_rsp.valid;
  assign inst_mem_req_ack = rsp_v;

  // Reads in flight already own a queue slot, so a returning word always fits.
  assign in_use = 32'(outstanding) + 32'(q_count);
  assign issue  = !reset && !redirect_valid &&
                  (32'(outstanding) < MAX_OUTSTANDING) && (in_use < DEPTH);

  always_comb begin
    inst_mem_req         = '0;
    inst_mem_req.addr    = fetch_pc;
    inst_mem_req.valid   = issue;
    inst_mem_req.do_read = issue ? 4'hF : 4'h0;
  end

  assign q_in   = '{pc: inst_mem_rsp.addr, instr: inst_mem_rsp.data};
  assign q_push = rsp_v && (discard == '0) && !redirect_valid && !reset && !q_full;
  assign q_pop  = instr_valid && instr_ready && !redirect_valid;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_empty ? '0 : q_head.instr;
  assign instr_pc    = q_empty ? '0 : q_head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= reset_pc;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge is stale, whether or not
      // some of it was already marked for discard.
      fetch_pc    <= redirect_pc & ~32'h3;
      outstanding <= outstanding - OW'(rsp_v);
      discard     <= outstanding - OW'(rsp_v);
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + OW'(issue) - OW'(rsp_v);
      if (rsp_v && discard != '0) discard <= discard - OW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (MAX_OUTSTANDING 4 and 2) share
// stimulus; a queue-level model is compared every cycle, plus literal checks.
module tb_fetch_unit;
  import memory_io_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, redirect_valid = 1'b0, instr_ready = 1'b1;
  logic [31:0] reset_pc = 32'h100, redirect_pc = '0;

  memory_io_req req [2];
  memory_io_rsp rsp [2] = '{default: '0};
  logic         ack [2], iv [2];
  logic [31:0]  ins [2], ipc [2];

  fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(4)) dut0 (
    .clk(clk), .reset(reset), .reset_pc(reset_pc),
    .inst_mem_req(req[0]), .inst_mem_rsp(rsp[0]), .inst_mem_req_ack(ack[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(iv[0]), .instr(ins[0]), .instr_pc(ipc[0]), .instr_ready(instr_ready));

  fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut1 (
    .clk(clk), .reset(reset), .reset_pc(reset_pc),
    .inst_mem_req(req[1]), .inst_mem_rsp(rsp[1]), .inst_mem_req_ack(ack[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(iv[1]), .instr(ins[1]), .instr_pc(ipc[1]), .instr_ready(instr_ready));

  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] a; int due; } mp_t;

  fl_t         infl [2][$];     // model: reads in flight, tagged stale by redirect
  logic [31:0] mq [2][$];       // model: queued pcs, head first
  logic [31:0] mpc [2];
  mp_t         pend [2][$];     // memory: accepted requests awaiting response
  logic [31:0] req_log [2][$], pop_log [2][$];
  int          max_infl [2];
  int          cyc = 0, lat = 1;
  bit          armed = 0;
  int          pass_cnt = 0, chk_cnt = 0;

  int  maxo;
  bit  ex_iss, ex_pop;
  fl_t f;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic string nm(input int i, input string s);
    return $sformatf("dut%0d.%s", i, s);
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory drives responses at negedge+1; compare and model step at negedge+2.
  always @(negedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      rsp[i] = '0;
      if (!reset && pend[i].size() > 0 && pend[i][0].due <= cyc) begin
        rsp[i].valid = 1'b1;
        rsp[i].addr  = pend[i][0].a;
        rsp[i].data  = word(pend[i][0].a);
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      maxo   = (i == 0) ? 4 : 2;
      ex_iss = !reset && !redirect_valid && infl[i].size() < maxo &&
               (infl[i].size() + mq[i].size()) < 4;
      if (armed) begin
        chk(nm(i, "req_valid"), 32'(req[i].valid), 32'(ex_iss));
        if (ex_iss) begin
          chk(nm(i, "req_addr"), req[i].addr, mpc[i]);
          chk(nm(i, "do_read"), 32'(req[i].do_read), 32'hF);
        end
        chk(nm(i, "do_write"), 32'(req[i].do_write), 32'h0);
        chk(nm(i, "ack"), 32'(ack[i]), 32'(rsp[i].valid));
        chk(nm(i, "instr_valid"), 32'(iv[i]), 32'(mq[i].size() > 0));
        if (mq[i].size() > 0) begin
          chk(nm(i, "instr_pc"), ipc[i], mq[i][0]);
          chk(nm(i, "instr"), ins[i], word(mq[i][0]));
        end
      end
      if (req[i].valid) req_log[i].push_back(req[i].addr);
      if (!reset && !redirect_valid && iv[i] && instr_ready) pop_log[i].push_back(ipc[i]);

      if (reset) begin
        infl[i].delete();
        mq[i].delete();
        mpc[i] = reset_pc;
      end else if (redirect_valid) begin
        for (int k = 0; k < infl[i].size(); k++) infl[i][k].stale = 1'b1;
        if (rsp[i].valid && infl[i].size() > 0) void'(infl[i].pop_front());
        mq[i].delete();
        mpc[i] = redirect_pc & ~32'h3;
      end else begin
        ex_pop = (mq[i].size() > 0) && instr_ready;
        if (rsp[i].valid && infl[i].size() > 0) begin
          f = infl[i].pop_front();
          if (!f.stale) mq[i].push_back(f.pc);
        end
        if (ex_pop) void'(mq[i].pop_front());
        if (ex_iss) begin
          infl[i].push_back('{pc: mpc[i], stale: 1'b0});
          mpc[i] = mpc[i] + 32'd4;
        end
      end

      if (reset) pend[i].delete();
      else begin
        if (rsp[i].valid) void'(pend[i].pop_front());
        if (req[i].valid) pend[i].push_back('{a: req[i].addr, due: cyc + lat});
      end
      if (pend[i].size() > max_infl[i]) max_infl[i] = pend[i].size();
    end
    if (reset) armed = 1'b1;
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_logs();
    for (int i = 0; i < 2; i++) begin
      req_log[i].delete();
      pop_log[i].delete();
      max_infl[i] = 0;
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1'b1;
    reset_pc = pc;
    redirect_valid = 1'b0;
    cyc_n(1);
    #3;
    chk("rst_instr_valid", 32'(iv[0]), 32'h0);
    chk("rst_instr", ins[0], 32'h0);
    chk("rst_instr_pc", ipc[0], 32'h0);
    chk("rst_req_valid", 32'(req[0].valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clr_logs();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc_n(1);
    redirect_valid = 1'b0;
  endtask

  int m, p;

  initial begin
    // Steady stream, 1-cycle memory
    lat = 1; instr_ready = 1'b1;
    do_reset(32'h100);
    cyc_n(12);
    for (int k = 0; k < 4; k++)
      chk($sformatf("stream_req%0d", k), qat(req_log[0], k), 32'h100 + 32'(4 * k));
    chk("stream_pops", 32'(pop_log[0].size()), 32'd10);
    chk("stream_first_pc", qat(pop_log[0], 0), 32'h100);
    chk("stream_last_pc", qat(pop_log[0], 9), 32'h124);

    // Back-pressure: credit stops issue at DEPTH
    instr_ready = 1'b0;
    do_reset(32'h100);
    cyc_n(10);
    chk("bp_reqs_dut0", 32'(req_log[0].size()), 32'd4);
    chk("bp_reqs_dut1", 32'(req_log[1].size()), 32'd4);
    #3;
    chk("bp_valid", 32'(iv[0]), 32'h1);
    chk("bp_head_pc", ipc[0], 32'h100);
    @(negedge clk);
    instr_ready = 1'b1;
    cyc_n(2);
    chk("bp_resume_reqs", 32'(req_log[0].size()), 32'd5);
    chk("bp_resume_addr", qat(req_log[0], 4), 32'h110);

    // 3-cycle memory, MAX_OUTSTANDING=2 instance
    lat = 3;
    do_reset(32'h100);
    cyc_n(30);
    chk("lat3_max_inflight", 32'(max_infl[1]), 32'd2);
    for (int k = 0; k < 8; k++)
      chk($sformatf("lat3_pc%0d", k), qat(pop_log[1], k), 32'h100 + 32'(4 * k));

    // Redirect with three reads in flight
    do_reset(32'h100);
    cyc_n(3);
    chk("redir_inflight", 32'(pend[0].size()), 32'd3);
    redirect(32'h200);
    cyc_n(15);
    chk("redir_next_req", qat(req_log[0], 3), 32'h200);
    chk("redir_first_pc", qat(pop_log[0], 0), 32'h200);
    chk("redir_second_pc", qat(pop_log[0], 1), 32'h204);

    // Back-to-back redirects while stale reads are still outstanding
    p = pop_log[0].size();
    redirect(32'h400);
    cyc_n(1);
    redirect(32'h500);
    cyc_n(15);
    chk("dbl_redir_pc", qat(pop_log[0], p), 32'h500);

    // Redirect coincident with response and pop; low bits ignored
    lat = 1;
    do_reset(32'h100);
    cyc_n(6);
    m = req_log[0].size();
    p = pop_log[0].size();
    redirect(32'h0000_0303);
    cyc_n(8);
    chk("coinc_req_addr", qat(req_log[0], m), 32'h300);
    chk("coinc_first_pc", qat(pop_log[0], p), 32'h300);

    // Address wrap
    m = req_log[0].size();
    p = pop_log[0].size();
    redirect(32'hFFFF_FFFC);
    cyc_n(8);
    chk("wrap_req0", qat(req_log[0], m), 32'hFFFF_FFFC);
    chk("wrap_req1", qat(req_log[0], m + 1), 32'h0000_0000);
    chk("wrap_pc0", qat(pop_log[0], p), 32'hFFFF_FFFC);
    chk("wrap_pc1", qat(pop_log[0], p + 1), 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
